// File: rtl/ysyx_22051145_divider.sv
// Iterative RV64M divide/remainder unit: radix-2 restoring division, one quotient
// bit per cycle, with a valid/ready handshake on both request and result sides.
module ysyx_22051145_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] dvs_q, dvs_d;
    logic        is_rem_q, is_rem_d;
    logic        word_q, word_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        spec_q, spec_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] out_data_q, out_data_d;
    logic [4:0]  out_rd_q, out_rd_d;

    function automatic logic [63:0] sext_w(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Sign fix-up: quotient negated on differing signs, remainder follows the dividend.
    function automatic logic [63:0] fixup(input logic [63:0] q, input logic [63:0] r,
                                          input logic is_rem, input logic qneg,
                                          input logic rneg, input logic word);
        logic signed [63:0] v;
        if (is_rem) v = rneg ? -$signed(r) : $signed(r);
        else        v = qneg ? -$signed(q) : $signed(q);
        return word ? sext_w(v[31:0]) : v;
    endfunction

    logic        in_signed;
    logic [63:0] a_prep, b_prep, a_abs, b_abs, spec_res;
    logic        a_neg, b_neg, div_zero, ovf;

    // Operand preparation on the request side, before anything is latched.
    always_comb begin
        in_signed = ~op[0];
        if (is_word) begin
            a_prep = {{32{in_signed & src1[31]}}, src1[31:0]};
            b_prep = {{32{in_signed & src2[31]}}, src2[31:0]};
        end else begin
            a_prep = src1;
            b_prep = src2;
        end
        a_neg    = in_signed & a_prep[63];
        b_neg    = in_signed & b_prep[63];
        a_abs    = a_neg ? (~a_prep + 64'd1) : a_prep;
        b_abs    = b_neg ? (~b_prep + 64'd1) : b_prep;
        div_zero = (b_prep == 64'd0);
        ovf      = in_signed & (b_prep == {64{1'b1}}) &
                   (is_word ? (a_prep[31:0] == 32'h8000_0000)
                            : (a_prep == {1'b1, 63'd0}));
        if (div_zero) spec_res = op[1] ? a_prep : {64{1'b1}};
        else          spec_res = op[1] ? 64'd0 : a_prep;
        if (is_word) spec_res = sext_w(spec_res[31:0]);
    end

    logic [64:0] shl, diff;
    logic        qbit;
    logic [6:0]  n_iter;

    always_comb begin
        shl    = {rem_q, quo_q[63]};
        diff   = shl - {1'b0, dvs_q};
        qbit   = ~diff[64];
        n_iter = word_q ? 7'd32 : 7'd64;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        is_rem_d   = is_rem_q;
        word_d     = word_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        spec_d     = spec_q;
        rd_d       = rd_q;
        out_data_d = out_data_q;
        out_rd_d   = out_rd_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d  = CALC;
                        cnt_d    = 7'd0;
                        is_rem_d = op[1];
                        word_d   = is_word;
                        rd_d     = rd;
                        qneg_d   = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        dvs_d    = b_abs;
                        rem_d    = 64'd0;
                        spec_d   = div_zero | ovf;
                        // Special results ride in the quotient register for one cycle.
                        if (div_zero | ovf) quo_d = spec_res;
                        else if (is_word)   quo_d = {a_abs[31:0], 32'd0};
                        else                quo_d = a_abs;
                    end
                end
                CALC: begin
                    if (spec_q) begin
                        out_data_d = quo_q;
                        out_rd_d   = rd_q;
                        state_d    = DONE;
                    end else if (cnt_q == n_iter) begin
                        out_data_d = fixup(quo_q, rem_q, is_rem_q, qneg_q, rneg_q, word_q);
                        out_rd_d   = rd_q;
                        state_d    = DONE;
                    end else begin
                        rem_d = qbit ? diff[63:0] : shl[63:0];
                        quo_d = {quo_q[62:0], qbit};
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            is_rem_q   <= 1'b0;
            word_q     <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            spec_q     <= 1'b0;
            rd_q       <= '0;
            out_data_q <= '0;
            out_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            is_rem_q   <= is_rem_d;
            word_q     <= word_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            spec_q     <= spec_d;
            rd_q       <= rd_d;
            out_data_q <= out_data_d;
            out_rd_q   <= out_rd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE) & ~flush;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_ysyx_22051145_divider.sv
// Directed bench for the iterative RV64M divider: results, latency, handshake,
// flush and reset behaviour against hand-computed expectations.
module tb_ysyx_22051145_divider;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, is_word, out_valid, out_ready, busy;
    logic [1:0]  op;
    logic [63:0] src1, src2, out_data;
    logic [4:0]  rd, out_rd;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] e;
        logic [6:0]  lat;
    } vec_t;

    vec_t vt[15];

    ysyx_22051145_divider #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_word(is_word), .src1(src1), .src2(src2), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Issue one request, scramble inputs after acceptance, wait (bounded) for out_valid.
    task automatic do_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] r,
                         output logic [63:0] d, output logic [4:0] ro, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op = o; is_word = w; src1 = a; src2 = b; rd = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        rd = ~r; op = ~o; is_word = ~w;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 200);
        d = out_data; ro = out_rd;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'd0; is_word = 1'b0; src1 = '0; src2 = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (out_data !== 64'd0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
    endtask

    task automatic test_vec_range(input int lo, input int hi);
        logic [63:0] d;
        logic [4:0]  ro;
        int          lat;
        for (int i = lo; i <= hi; i++) begin
            do_op(vt[i].op, vt[i].w, vt[i].a, vt[i].b, 5'(i + 5), d, ro, lat);
            n_vec++; if (d !== vt[i].e) begin n_err++; $display("FAIL vec%0d_data: got %h want %h", i, d, vt[i].e); end
            n_vec++; if (ro !== 5'(i + 5)) begin n_err++; $display("FAIL vec%0d_rd: got %0d want %0d", i, ro, i + 5); end
            n_vec++; if (lat !== int'(vt[i].lat)) begin n_err++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vt[i].lat); end
            handshake();
        end
    endtask

    task automatic test_div64();   test_vec_range(0, 3);  endtask
    task automatic test_special(); test_vec_range(4, 8);  endtask
    task automatic test_word();    test_vec_range(9, 14); endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic [4:0]  ro;
        int          lat;
        out_ready = 1'b0;
        do_op(2'd0, 1'b0, 64'd1000, 64'd10, 5'd9, d, ro, lat);
        n_vec++; if (d !== 64'd100) begin n_err++; $display("FAIL bp_data: got %h want 64", d); end
        n_vec++; if (lat !== 65) begin n_err++; $display("FAIL bp_latency: got %0d want 65", lat); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 64'd100 || out_rd !== 5'd9 ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rd=%0d ir=%b busy=%b want v=1 d=64 rd=9 ir=0 busy=1",
                         k, out_valid, out_data, out_rd, in_ready, busy);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
        do_op(2'd1, 1'b0, 64'd7, 64'd0, 5'd3, d, ro, lat);
        n_vec++; if (d !== {64{1'b1}} || ro !== 5'd3) begin n_err++; $display("FAIL b2b_result: got %h rd=%0d want ffffffffffffffff rd=3", d, ro); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL b2b_latency: got %0d want 1", lat); end
        handshake();
    endtask

    task automatic test_flush();
        logic [63:0] d;
        logic [4:0]  ro;
        int          lat;
        int          seen;
        @(negedge clk);
        in_valid = 1'b1; op = 2'd0; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd3; rd = 5'd7;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n_vec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_calc_idle: got busy=%b ir=%b want busy=0 ir=1", busy, in_ready); end
        seen = 0;
        repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL flush_calc_no_result: got %0d valid cycles want 0", seen); end

        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 2'd1; src1 = 64'd5; src2 = 64'd0;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_reject: got busy=%b want 0", busy); end
        seen = 0;
        repeat (4) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL flush_idle_no_result: got %0d valid cycles want 0", seen); end

        out_ready = 1'b0;
        do_op(2'd1, 1'b0, 64'd9, 64'd0, 5'd12, d, ro, lat);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_done_pre: got out_valid=%b want 1", out_valid); end
        flush = 1'b1; #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_mask: got out_valid=%b want 0", out_valid); end
        @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_idle: got busy=%b v=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_rst_mid();
        logic [63:0] d;
        logic [4:0]  ro;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1; op = 2'd0; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd3; rd = 5'd7;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_vec++;
        if (out_data !== 64'd0 || out_rd !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_calc: got d=%h rd=%0d busy=%b ir=%b v=%b want 0 0 0 1 0", out_data, out_rd, busy, in_ready, out_valid);
        end

        out_ready = 1'b0;
        do_op(2'd0, 1'b0, 64'd77, 64'd0, 5'd20, d, ro, lat);
        n_vec++; if (d !== {64{1'b1}} || ro !== 5'd20) begin n_err++; $display("FAIL rst_done_pre: got %h rd=%0d want ffffffffffffffff rd=20", d, ro); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (out_data !== 64'd0 || out_rd !== 5'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_done: got d=%h rd=%0d busy=%b v=%b want 0 0 0 0", out_data, out_rd, busy, out_valid);
        end

        do_op(2'd0, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd5, d, ro, lat);
        n_vec++; if (d !== 64'hFFFF_FFFF_FFFF_FFF2 || ro !== 5'd5 || lat !== 65) begin
            n_err++; $display("FAIL rst_recover: got %h rd=%0d lat=%0d want fffffffffffffff2 rd=5 lat=65", d, ro, lat);
        end
        handshake();
    endtask

    initial begin
        // op: 0 DIV, 1 DIVU, 2 REM, 3 REMU
        vt[0]  = '{2'd0, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 7'd65};
        vt[1]  = '{2'd2, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 7'd65};
        vt[2]  = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 7'd65};
        vt[3]  = '{2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 7'd65};
        vt[4]  = '{2'd1, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd1};
        vt[5]  = '{2'd3, 1'b0, 64'd123, 64'd0, 64'd123, 7'd1};
        vt[6]  = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 7'd1};
        vt[7]  = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 7'd1};
        vt[8]  = '{2'd3, 1'b1, 64'h1111_1111_8000_0000, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 7'd1};
        vt[9]  = '{2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 7'd33};
        vt[10] = '{2'd2, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 7'd33};
        vt[11] = '{2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 7'd1};
        vt[12] = '{2'd0, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 7'd33};
        vt[13] = '{2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd33};
        vt[14] = '{2'd3, 1'b1, 64'h0000_0000_8000_0005, 64'h10, 64'd5, 7'd33};

        test_reset();
        test_div64();
        test_special();
        test_word();
        test_back_to_back();
        test_flush();
        test_rst_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22051145_divider.md
Name: ysyx_22051145_divider

Overview:
- Iterative RV64M divide/remainder unit in the execute stage.
- Consumes the two register-file read operands and produces one 64-bit result tagged with its destination register.
- The result is written back through the register file write port (w_data/waddr/en_w).
- Covers DIV, DIVU, REM, REMU and their W variants, using radix-2 restoring division with a valid/ready handshake on both sides.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  pipeline flush; aborts any operation in flight.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- is_word  input  1  1 selects the W variant (32-bit operation).
- src1  input  64  dividend (rdata_1).
- src2  input  64  divisor (rdata_2).
- rd  input  5  destination register; passed through to out_rd.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- out_data  output  64  quotient or remainder.
- out_rd  output  5  destination register of the result.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a posedge, the unit goes to state IDLE, with out_data=0, out_rd=0, iteration counter=0 and all operand registers 0. After reset: in_ready=1, out_valid=0, busy=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready&!flush, latch op, is_word, rd and the operands.
  - Special case: if the prepared divisor is 0, or the operation is signed overflow (most negative dividend / -1), load the result directly and go to DONE.
  - Otherwise go to CALC with count=0.
  - CALC: one quotient bit per cycle. The operation holds CALC for N cycles, where N=64 for 64-bit ops and N=32 for W ops. After the last iteration, apply sign fix-up, register out_data, and go to DONE.
  - DONE: out_valid=(state==DONE)&!flush. out_data and out_rd are held stable. On out_valid&out_ready, go to IDLE.
- Latency: with the request accepted at edge T:
  - Normal: out_valid rises after edge T+N+1 (65 cycles for 64-bit, 33 for W).
  - Special cases: out_valid rises after edge T+1.
  - Back-to-back: a new request can be accepted in the cycle after the output handshake completes. There is no overlap; in_ready=0 in CALC and DONE.
- Operand preparation:
  - W ops use src[31:0], sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed ops divide the absolute values; the sign is recorded.
- Result rules:
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones, remainder = dividend (after W preparation).
  - Signed overflow: quotient = dividend, remainder = 0.
  - W ops: the 32-bit result is sign-extended from bit 31 to 64 bits. This includes DIVUW and REMUW.
- Flush:
  - Highest priority after rst. In any state, the next state is IDLE and no result is produced.
  - In IDLE, a request is not accepted in a flush cycle.
  - In DONE, out_valid is forced low in the flush cycle.
- Reset mid-CALC or mid-DONE: the operation is dropped and the outputs take their reset values.
- Operand and rd inputs are sampled only at acceptance; later changes are ignored.

Test Plan:
- DIV src1=100, src2=-7 (0xFFFF_FFFF_FFFF_FFF9), rd=5, out_ready=1 -> out_data=0xFFFF_FFFF_FFFF_FFF2 (-14), out_rd=5, out_valid after exactly 65 cycles. REM with the same operands -> 2.
- DIVU src2=0, src1=123 -> out_data=0xFFFF_FFFF_FFFF_FFFF after 1 cycle. REMU with the same operands -> 123.
- DIV src1=0x8000_0000_0000_0000, src2=-1 -> 0x8000_0000_0000_0000 after 1 cycle. REM -> 0.
- W ops:
  - DIVUW src1=0x0000_0000_FFFF_FFFE, src2=2 -> 0x0000_0000_7FFF_FFFF after 33 cycles.
  - REMW src1=0x1234_5678_FFFF_FFF9 (-7), src2=2 -> 0xFFFF_FFFF_FFFF_FFFF.
  - DIVW src1=0x8000_0000, src2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- Backpressure: out_ready held at 0 for 5 cycles after out_valid rises -> out_data and out_rd stable, in_ready=0, busy=1. When out_ready rises, the handshake completes; the next cycle has in_ready=1 and a new request is accepted.
- Flush 10 cycles into CALC -> next cycle state IDLE, in_ready=1, out_valid never rises. Then assert flush together with in_valid in IDLE -> not accepted. Repeat with rst instead of flush mid-CALC -> outputs at reset values, busy=0.
